// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcode/funct
// constants and datapath select codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FETCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_MEMADDR = 4'd3,
        ST_MEMRD   = 4'd4,
        ST_MEMWB   = 4'd5,
        ST_MEMWR   = 4'd6,
        ST_EXEC_R  = 4'd7,
        ST_R_WB    = 4'd8,
        ST_EXEC_I  = 4'd9,
        ST_I_WB    = 4'd10,
        ST_BRANCH  = 4'd11,
        ST_JUMP    = 4'd12,
        ST_TRAP    = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    localparam logic [1:0] BSEL_REG    = 2'd0;
    localparam logic [1:0] BSEL_FOUR   = 2'd1;
    localparam logic [1:0] BSEL_IMM    = 2'd2;
    localparam logic [1:0] BSEL_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    function automatic logic funct_valid(input logic [5:0] f);
        case (f)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_valid = 1'b1;
            default:                               funct_valid = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational map of (state, opcode, funct) to ALU operation and
// immediate-extension mode.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_ctl,
    output logic       ext_sel
);

    // ALU op and extender mode per state; I_WB keeps the EXEC_I extender mode
    always_comb begin
        alu_ctl = ALU_ADD;
        ext_sel = 1'b0;
        case (state)
            ST_DECODE, ST_MEMADDR: ext_sel = 1'b1;
            ST_EXEC_R: begin
                case (funct)
                    FN_SUB:  alu_ctl = ALU_SUB;
                    FN_AND:  alu_ctl = ALU_AND;
                    FN_OR:   alu_ctl = ALU_OR;
                    FN_SLT:  alu_ctl = ALU_SLT;
                    default: alu_ctl = ALU_ADD;
                endcase
            end
            ST_EXEC_I: begin
                case (opcode)
                    OP_ADDI: begin ext_sel = 1'b1; alu_ctl = ALU_ADD; end
                    OP_SLTI: begin ext_sel = 1'b1; alu_ctl = ALU_SLT; end
                    OP_ANDI: begin ext_sel = 1'b0; alu_ctl = ALU_AND; end
                    OP_ORI:  begin ext_sel = 1'b0; alu_ctl = ALU_OR;  end
                    default: begin ext_sel = 1'b0; alu_ctl = ALU_ADD; end
                endcase
            end
            ST_I_WB: begin
                case (opcode)
                    OP_ADDI, OP_SLTI: ext_sel = 1'b1;
                    default:          ext_sel = 1'b0;
                endcase
            end
            ST_BRANCH: alu_ctl = ALU_SUB;
            default:   alu_ctl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM with Moore-decoded datapath controls.
// Optional retired-instruction counter enabled by MC_CTRL_PERF_EN.
module mips_mc_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       iord,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic       ext_sel,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_ctl,
    output logic       illegal,
    output logic [3:0] state
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] retired
`endif
);

    state_t state_r;
    state_t next_s;
    logic   start_r;

    // State register; start_r holds IDLE for one extra edge after reset release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            start_r <= 1'b0;
        end else begin
            state_r <= next_s;
            start_r <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE:  if (start_r) next_s = ST_FETCH; else next_s = ST_IDLE;
            ST_FETCH: if (mem_ready) next_s = ST_DECODE; else next_s = ST_FETCH;
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:                            next_s = ST_EXEC_R;
                    OP_LW, OP_SW:                        next_s = ST_MEMADDR;
                    OP_BEQ:                              next_s = ST_BRANCH;
                    OP_J:                                next_s = ST_JUMP;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:   next_s = ST_EXEC_I;
                    default:                             next_s = ST_TRAP;
                endcase
            end
            ST_MEMADDR: begin
                case (opcode)
                    OP_LW:   next_s = ST_MEMRD;
                    OP_SW:   next_s = ST_MEMWR;
                    default: next_s = ST_TRAP;
                endcase
            end
            ST_MEMRD: if (mem_ready) next_s = ST_MEMWB; else next_s = ST_MEMRD;
            ST_MEMWR: if (mem_ready) next_s = ST_FETCH; else next_s = ST_MEMWR;
            ST_EXEC_R: if (funct_valid(funct)) next_s = ST_R_WB; else next_s = ST_TRAP;
            ST_EXEC_I: next_s = ST_I_WB;
            ST_MEMWB, ST_R_WB, ST_I_WB, ST_BRANCH, ST_JUMP: next_s = ST_FETCH;
            ST_TRAP:  next_s = ST_TRAP;
            default:  next_s = ST_TRAP;
        endcase
    end

    // Datapath strobes and selects decoded from the current state
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        iord       = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = BSEL_REG;
        pc_src     = PCSRC_ALU;
        illegal    = 1'b0;
        case (state_r)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = BSEL_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            ST_DECODE:  alu_src_b = BSEL_IMM_SH;
            ST_MEMADDR: begin alu_src_a = 1'b1; alu_src_b = BSEL_IMM; end
            ST_MEMRD:   begin iord = 1'b1; mem_read = 1'b1; end
            ST_MEMWR:   begin iord = 1'b1; mem_write = 1'b1; end
            ST_MEMWB:   begin reg_write = 1'b1; mem_to_reg = 1'b1; end
            ST_EXEC_R:  alu_src_a = 1'b1;
            ST_R_WB:    begin reg_write = 1'b1; reg_dst = 1'b1; end
            ST_EXEC_I:  begin alu_src_a = 1'b1; alu_src_b = BSEL_IMM; end
            ST_I_WB:    reg_write = 1'b1;
            ST_BRANCH: begin
                alu_src_a = 1'b1;
                pc_src    = PCSRC_ALUOUT;
                pc_write  = zero;
            end
            ST_JUMP:    begin pc_write = 1'b1; pc_src = PCSRC_JUMP; end
            ST_TRAP:    illegal = 1'b1;
            default:    illegal = 1'b0;
        endcase
    end

    assign state = state_r;

    mips_alu_decoder u_alu_decoder (
        .state   (state_r),
        .opcode  (opcode),
        .funct   (funct),
        .alu_ctl (alu_ctl),
        .ext_sel (ext_sel)
    );

`ifdef MC_CTRL_PERF_EN
    logic [31:0] retired_r;

    // Count instruction completions: entries into FETCH other than from IDLE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retired_r <= 32'd0;
        end else if (next_s == ST_FETCH && state_r != ST_FETCH && state_r != ST_IDLE) begin
            retired_r <= retired_r + 32'd1;
        end else begin
            retired_r <= retired_r;
        end
    end

    assign retired = retired_r;
`endif

endmodule

// File: tb/tb_mips_mc_control.sv
// Randomized self-checking bench for mips_mc_control against a per-instruction
// state-sequence model and a per-state output table.
module tb_mips_mc_control;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       pc_write, ir_write, mem_read, mem_write, reg_write;
    logic       iord, reg_dst, mem_to_reg, alu_src_a, ext_sel, illegal;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_ctl;
    logic [3:0] state;
    logic [17:0] obs;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] retired;
    logic [31:0] ret_exp;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    assign obs = {pc_write, ir_write, mem_read, mem_write, reg_write, iord, reg_dst,
                  mem_to_reg, alu_src_a, ext_sel, alu_src_b, pc_src, alu_ctl, illegal};

    mips_mc_control dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .iord(iord), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .ext_sel(ext_sel), .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_ctl(alu_ctl),
        .illegal(illegal), .state(state)
`ifdef MC_CTRL_PERF_EN
        , .retired(retired)
`endif
    );

    // Output table straight from the state descriptions
    function automatic logic [17:0] exp_out(input logic [3:0] st, input logic [5:0] op,
                                            input logic [5:0] fn, input logic mr, input logic z);
        logic pcw, irw, mrd, mwr, rw, io, rd, m2r, asa, ext, ill;
        logic [1:0] asb, pcs;
        logic [2:0] alu;
        {pcw, irw, mrd, mwr, rw, io, rd, m2r, asa, ext, ill} = 11'd0;
        asb = 2'd0; pcs = 2'd0; alu = 3'd0;
        case (st)
            ST_FETCH:   begin mrd = 1'b1; asb = 2'd1; irw = mr; pcw = mr; end
            ST_DECODE:  begin asb = 2'd3; ext = 1'b1; end
            ST_MEMADDR: begin asa = 1'b1; asb = 2'd2; ext = 1'b1; end
            ST_MEMRD:   begin io = 1'b1; mrd = 1'b1; end
            ST_MEMWR:   begin io = 1'b1; mwr = 1'b1; end
            ST_MEMWB:   begin rw = 1'b1; m2r = 1'b1; end
            ST_EXEC_R: begin
                asa = 1'b1;
                if (fn == 6'b100010) alu = 3'd1;
                else if (fn == 6'b100100) alu = 3'd2;
                else if (fn == 6'b100101) alu = 3'd3;
                else if (fn == 6'b101010) alu = 3'd4;
                else alu = 3'd0;
            end
            ST_R_WB:    begin rw = 1'b1; rd = 1'b1; end
            ST_EXEC_I: begin
                asa = 1'b1; asb = 2'd2;
                ext = (op == 6'b001000 || op == 6'b001010);
                if (op == 6'b001010) alu = 3'd4;
                else if (op == 6'b001100) alu = 3'd2;
                else if (op == 6'b001101) alu = 3'd3;
                else alu = 3'd0;
            end
            ST_I_WB:    begin rw = 1'b1; ext = (op == 6'b001000 || op == 6'b001010); end
            ST_BRANCH:  begin asa = 1'b1; alu = 3'd1; pcs = 2'd1; pcw = z; end
            ST_JUMP:    begin pcw = 1'b1; pcs = 2'd2; end
            ST_TRAP:    ill = 1'b1;
            default:    ill = 1'b0;
        endcase
        return {pcw, irw, mrd, mwr, rw, io, rd, m2r, asa, ext, asb, pcs, alu, ill};
    endfunction

    // Expected state walk of one instruction, including wait cycles
    task automatic build_seq(input logic [5:0] op, input logic [5:0] fn, input int wf, input int wm);
        exp_q.delete();
        repeat (wf + 1) exp_q.push_back(ST_FETCH);
        exp_q.push_back(ST_DECODE);
        case (op)
            6'b000000: begin
                exp_q.push_back(ST_EXEC_R);
                if (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010})
                    exp_q.push_back(ST_R_WB);
                else
                    exp_q.push_back(ST_TRAP);
            end
            6'b100011: begin
                exp_q.push_back(ST_MEMADDR);
                repeat (wm + 1) exp_q.push_back(ST_MEMRD);
                exp_q.push_back(ST_MEMWB);
            end
            6'b101011: begin
                exp_q.push_back(ST_MEMADDR);
                repeat (wm + 1) exp_q.push_back(ST_MEMWR);
            end
            6'b000100: exp_q.push_back(ST_BRANCH);
            6'b000010: exp_q.push_back(ST_JUMP);
            6'b001000, 6'b001010, 6'b001100, 6'b001101: begin
                exp_q.push_back(ST_EXEC_I);
                exp_q.push_back(ST_I_WB);
            end
            default: exp_q.push_back(ST_TRAP);
        endcase
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int wf, input int wm, input string name);
        int fw = wf;
        int mw = wm;
        logic [3:0] st;
        build_seq(op, fn, wf, wm);
        zero = z;
        foreach (exp_q[i]) begin
            @(negedge clk);
            opcode = op; funct = fn;
            st = exp_q[i];
            if (st == ST_FETCH) begin
                mem_ready = (fw == 0); if (fw > 0) fw--;
            end else if (st == ST_MEMRD || st == ST_MEMWR) begin
                mem_ready = (mw == 0); if (mw > 0) mw--;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            n_cmp++;
            if (state !== st) begin
                n_fail++;
                $display("FAIL %s state cyc%0d: got %0d want %0d", name, i, state, st);
            end
            n_cmp++;
            if (obs !== exp_out(st, op, fn, mem_ready, z)) begin
                n_fail++;
                $display("FAIL %s outputs cyc%0d st%0d: got %h want %h", name, i, st, obs,
                         exp_out(st, op, fn, mem_ready, z));
            end
        end
        if (exp_q[exp_q.size()-1] != ST_TRAP) begin
            @(posedge clk); #1;
            n_cmp++;
            if (state !== ST_FETCH) begin
                n_fail++;
                $display("FAIL %s return: got state %0d want %0d", name, state, ST_FETCH);
            end
`ifdef MC_CTRL_PERF_EN
            ret_exp = ret_exp + 32'd1;
            n_cmp++;
            if (retired !== ret_exp) begin
                n_fail++;
                $display("FAIL %s retired: got %0d want %0d", name, retired, ret_exp);
            end
`endif
        end
    endtask

    // Release reset and advance to the first FETCH cycle
    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; mem_ready = 1'b1; zero = 1'b1; opcode = 6'd0; funct = 6'd0;
`ifdef MC_CTRL_PERF_EN
        ret_exp = 32'd0;
`endif
        repeat (2) @(negedge clk);
        n_cmp++;
        if (state !== ST_IDLE || obs !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_hold: state %0d outs %h want %0d / 0", state, obs, ST_IDLE);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_edge1: got %0d want %0d", state, ST_IDLE);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (state !== ST_FETCH) begin
            n_fail++;
            $display("FAIL reset_edge2: got %0d want %0d", state, ST_FETCH);
        end
    endtask

    task automatic test_directed();
        run_instr(6'b000000, 6'b100000, 1'b0, 0, 0, "add");
        run_instr(6'b100011, 6'd0, 1'b0, 0, 2, "lw_wait2");
        run_instr(6'b101011, 6'd0, 1'b0, 1, 1, "sw_wait");
        run_instr(6'b000100, 6'd0, 1'b1, 0, 0, "beq_taken");
        run_instr(6'b000100, 6'd0, 1'b0, 0, 0, "beq_not");
        run_instr(6'b001101, 6'd0, 1'b0, 0, 0, "ori");
        run_instr(6'b001000, 6'd0, 1'b0, 0, 0, "addi");
        run_instr(6'b000010, 6'd0, 1'b0, 2, 0, "j_fwait");
    endtask

    task automatic test_random();
        logic [5:0] ops [9] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                                6'b001000, 6'b001010, 6'b001100, 6'b001101};
        logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        for (int k = 0; k < 40; k++) begin
            run_instr(ops[$urandom_range(0, 8)], fns[$urandom_range(0, 4)],
                      1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2),
                      "random");
        end
    endtask

    task automatic test_reset_midaccess();
        run_instr(6'b000000, 6'b100101, 1'b0, 0, 0, "or");
        @(negedge clk); opcode = 6'b100011; mem_ready = 1'b1;
        @(negedge clk); @(negedge clk); @(negedge clk);
        mem_ready = 1'b0; #1;
        n_cmp++;
        if (state !== ST_MEMRD || mem_read !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_setup: state %0d mem_read %b want %0d 1", state, mem_read, ST_MEMRD);
        end
        reset_n = 1'b0; #1;
        n_cmp++;
        if (state !== ST_IDLE || obs !== 18'd0) begin
            n_fail++;
            $display("FAIL mid_reset: state %0d outs %h want %0d / 0", state, obs, ST_IDLE);
        end
`ifdef MC_CTRL_PERF_EN
        ret_exp = 32'd0;
        n_cmp++;
        if (retired !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_reset retired: got %0d want 0", retired);
        end
`endif
        release_reset();
    endtask

    task automatic test_trap(input logic [5:0] op, input logic [5:0] fn, input string name);
        run_instr(op, fn, 1'b0, 0, 0, name);
        repeat (3) begin
            @(negedge clk); mem_ready = 1'($urandom_range(0, 1)); #1;
            n_cmp++;
            if (state !== ST_TRAP || obs !== 18'd1) begin
                n_fail++;
                $display("FAIL %s sticky: state %0d outs %h want %0d / 1", name, state, obs, ST_TRAP);
            end
        end
        reset_n = 1'b0; #1;
        n_cmp++;
        if (illegal !== 1'b0 || state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL %s clear: illegal %b state %0d want 0 %0d", name, illegal, state, ST_IDLE);
        end
`ifdef MC_CTRL_PERF_EN
        ret_exp = 32'd0;
`endif
        release_reset();
        n_cmp++;
        if (state !== ST_FETCH) begin
            n_fail++;
            $display("FAIL %s refetch: got %0d want %0d", name, state, ST_FETCH);
        end
    endtask

`ifdef MC_CTRL_PERF_EN
    task automatic test_perf_wrap();
        @(negedge clk);
        dut.retired_r = 32'hFFFF_FFFE;
        ret_exp = 32'hFFFF_FFFE;
        run_instr(6'b000010, 6'd0, 1'b0, 0, 0, "wrap_a");
        run_instr(6'b000010, 6'd0, 1'b0, 0, 0, "wrap_b");
        run_instr(6'b000100, 6'd0, 1'b1, 0, 0, "wrap_c");
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_reset_midaccess();
        test_trap(6'b111111, 6'd0, "trap_op");
        test_trap(6'b000000, 6'b111111, "trap_funct");
        run_instr(6'b000000, 6'b101010, 1'b0, 0, 0, "slt_after_trap");
`ifdef MC_CTRL_PERF_EN
        test_perf_wrap();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
